// File: rtl/lap_stopwatch.sv
// lap_stopwatch: BCD M:SS.t stopwatch core with up/down counting, preset load,
// count-down expiry and an indexed lap (split) memory.
// Time word layout everywhere: {min, sec_msd, sec_lsd, tenth}, one BCD digit each.
module lap_stopwatch #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int LAP_DEPTH = 8,
    parameter int IDX_W     = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    parameter int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             lap,
    input  logic             dir,
    input  logic             load,
    input  logic [15:0]      load_val,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [15:0]      cur_time,
    output logic [15:0]      lap_time,
    output logic [CNT_W-1:0] lap_count,
    output logic             lap_full,
    output logic             running,
    output logic             expired,
    output logic             tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    // Button bit positions inside the edge-detector vectors
    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_CLR   = 2;
    localparam int B_LOAD  = 3;
    localparam int B_LAP   = 4;
    localparam int NBTN    = 5;

    // ------------------------------------------------------------------
    // BCD step helpers
    // ------------------------------------------------------------------
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] m, s1, s0, d;
        {m, s1, s0, d} = t;
        if (d != 4'd9) begin
            d = d + 4'd1;
        end else begin
            d = 4'd0;
            if (s0 != 4'd9) begin
                s0 = s0 + 4'd1;
            end else begin
                s0 = 4'd0;
                if (s1 != 4'd5) begin
                    s1 = s1 + 4'd1;
                end else begin
                    s1 = 4'd0;
                    m  = (m != 4'd9) ? m + 4'd1 : 4'd0;
                end
            end
        end
        return {m, s1, s0, d};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m, s1, s0, d;
        {m, s1, s0, d} = t;
        if (d != 4'd0) begin
            d = d - 4'd1;
        end else begin
            d = 4'd9;
            if (s0 != 4'd0) begin
                s0 = s0 - 4'd1;
            end else begin
                s0 = 4'd9;
                if (s1 != 4'd0) begin
                    s1 = s1 - 4'd1;
                end else begin
                    s1 = 4'd5;
                    m  = (m != 4'd0) ? m - 4'd1 : 4'd9;
                end
            end
        end
        return {m, s1, s0, d};
    endfunction

    // ------------------------------------------------------------------
    // Button edge detection: history flop plus a registered event pulse.
    // History resets low, so a button held through reset fires once.
    // ------------------------------------------------------------------
    logic [NBTN-1:0] btn;
    logic [NBTN-1:0] hist_q;
    logic [NBTN-1:0] ev_q;

    assign btn = {lap, load, clr, stop, start};

    // Sample buttons and register their rising-edge events
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            ev_q   <= '0;
        end else begin
            hist_q <= btn;
            ev_q   <= btn & ~hist_q;
        end
    end

    logic ev_start, ev_stop, ev_clr, ev_load, ev_lap;
    assign ev_start = ev_q[B_START];
    assign ev_stop  = ev_q[B_STOP];
    assign ev_clr   = ev_q[B_CLR];
    assign ev_load  = ev_q[B_LOAD];
    assign ev_lap   = ev_q[B_LAP];

    // ------------------------------------------------------------------
    // Preset validation: every digit <= 9, tens-of-seconds digit <= 5
    // ------------------------------------------------------------------
    logic [3:0] dig_ok;
    logic       load_ok;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dig_chk
        localparam logic [3:0] LIM = (gi == 2) ? 4'd5 : 4'd9;
        assign dig_ok[gi] = (load_val[gi*4 +: 4] <= LIM);
    end

    assign load_ok = &dig_ok;

    // ------------------------------------------------------------------
    // Core state
    // ------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic [15:0]      cur_q,     cur_d;
    logic             expired_q, expired_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             tick_q,    tick_d;
    logic             running_q;
    logic             lap_full_q;
    logic             lap_we;
    logic [15:0]      step_val;
    logic             lap_ok;

    assign step_val = dir ? bcd_inc(cur_q) : bcd_dec(cur_q);
    assign lap_ok   = ev_lap && (state_q == S_RUN) && !lap_full_q;

    // Next-state: tick-driven counting first, then button events by priority
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cur_d     = cur_q;
        expired_d = expired_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        lap_we    = 1'b0;

        if (state_q == S_RUN) begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
                cur_d   = step_val;
                if (!dir && (step_val == 16'h0000)) begin
                    expired_d = 1'b1;
                    state_d   = S_PAUSE;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (ev_clr) begin
            state_d   = S_IDLE;
            cur_d     = 16'h0000;
            cnt_d     = '0;
            presc_d   = '0;
            expired_d = 1'b0;
            tick_d    = 1'b0;
        end else if (ev_stop) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end
            // A lap arriving with stop still captures the pre-stop time
            if (lap_ok) begin
                lap_we = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else if (ev_start) begin
            // Starting a down-count already at zero would expire instantly
            if ((state_q != S_RUN) && !(!dir && (cur_q == 16'h0000))) begin
                state_d   = S_RUN;
                presc_d   = '0;
                expired_d = 1'b0;
            end
        end else if (ev_load) begin
            if ((state_q != S_RUN) && load_ok) begin
                cur_d     = load_val;
                expired_d = 1'b0;
            end
        end else if (lap_ok) begin
            lap_we = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // Core registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            cur_q      <= 16'h0000;
            expired_q  <= 1'b0;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
            lap_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cur_q      <= cur_d;
            expired_q  <= expired_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            running_q  <= (state_q == S_RUN);
            lap_full_q <= (cnt_d == CNT_W'(LAP_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Lap memory: plain array with registered read so it maps to block RAM.
    // Entries past lap_count are masked by a separately registered valid bit.
    // ------------------------------------------------------------------
    logic [15:0] lap_mem [LAP_DEPTH];
    logic [15:0] lap_rd_q;
    logic        lap_vld_q;

    // Lap write port; index is the current entry count
    always_ff @(posedge clk) begin
        if (lap_we && rst) begin
            lap_mem[cnt_q[IDX_W-1:0]] <= cur_q;
        end
    end

    // Lap read port, one cycle latency from rd_idx
    always_ff @(posedge clk) begin
        lap_rd_q <= lap_mem[rd_idx];
    end

    // Read-valid mask register
    always_ff @(posedge clk) begin
        if (!rst) begin
            lap_vld_q <= 1'b0;
        end else begin
            lap_vld_q <= (32'(rd_idx) < 32'(cnt_q));
        end
    end

    assign cur_time  = cur_q;
    assign lap_time  = lap_vld_q ? lap_rd_q : 16'h0000;
    assign lap_count = cnt_q;
    assign lap_full  = lap_full_q;
    assign running   = running_q;
    assign expired   = expired_q;
    assign tick      = tick_q;

endmodule
